// File: rtl/vc_test_multi_rand_delay_source.sv
// Multi-channel val/rdy test source: each channel walks its own slice of a shared,
// bench-loaded memory with an independent seed-reproducible inter-message delay.
module vc_test_multi_rand_delay_source #(
    parameter int unsigned p_msg_nbits = 32,
    parameter int unsigned p_num_msgs  = 1024,
    parameter int unsigned p_nchans    = 2,
    parameter logic [31:0] p_seed      = 32'hB5AD4ECE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      mode,
    input  logic [31:0]                     max_delay,
    input  logic [p_nchans*32-1:0]          nmsgs,
    output logic [p_nchans-1:0]             val,
    input  logic [p_nchans-1:0]             rdy,
    output logic [p_nchans*p_msg_nbits-1:0] msg,
    output logic [p_nchans-1:0]             chan_done,
    output logic                            done
);
    localparam int unsigned IW        = $clog2(p_num_msgs + 1);
    localparam int unsigned DEPTH     = p_nchans * p_num_msgs;
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_INIT, S_DELAY, S_VALID, S_DONE} state_t;

    // Loaded hierarchically by the bench; this block only reads it.
    logic [p_msg_nbits-1:0] m [DEPTH];

    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // 33-bit arithmetic so max_delay = 0xFFFFFFFF never wraps the modulus.
    function automatic logic [31:0] f_draw(input logic [1:0]  md,
                                           input logic [31:0] mx,
                                           input logic [31:0] lf);
        logic [32:0] lo;
        logic [32:0] span;
        logic [32:0] r;
        lo   = {2'b00, mx[31:1]};
        span = 33'd0;
        r    = 33'd0;
        case (md)
            2'd0: r = 33'd0;
            2'd1: r = {1'b0, mx};
            2'd2: begin
                span = {1'b0, mx} + 33'd1;
                r    = {1'b0, lf} % span;
            end
            default: begin
                span = {1'b0, mx} - lo + 33'd1;
                r    = lo + ({1'b0, lf} % span);
            end
        endcase
        return 32'(r);
    endfunction

    for (genvar c = 0; c < p_nchans; c++) begin : g_chan
        localparam logic [31:0]   SEED_RAW = p_seed ^ (32'(c) * 32'h9E3779B9);
        localparam logic [31:0]   SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;
        localparam logic [AW-1:0] BASE     = AW'(c * p_num_msgs);

        state_t        r_state;
        logic [31:0]   r_cnt;
        logic [IW-1:0] r_idx;
        logic [IW-1:0] r_n;
        logic [31:0]   r_lfsr;

        state_t        w_state_nxt;
        logic [31:0]   w_cnt_nxt;
        logic [IW-1:0] w_idx_nxt;
        logic [IW-1:0] w_n_nxt;
        logic [31:0]   w_lfsr_nxt;
        logic          w_val;
        logic          w_chan_done;

        logic [31:0]   w_n_req;
        logic [IW-1:0] w_n_clamp;
        logic [31:0]   w_d;
        logic [31:0]   w_lfsr_step;
        logic [IW-1:0] w_idx_inc;
        logic [IW-1:0] w_rd_idx;
        logic [AW-1:0] w_addr;

        assign w_n_req     = nmsgs[32*c +: 32];
        assign w_n_clamp   = (w_n_req > 32'(p_num_msgs)) ? IW'(p_num_msgs) : IW'(w_n_req);
        assign w_d         = f_draw(mode, max_delay, r_lfsr);
        assign w_lfsr_step = f_lfsr_step(r_lfsr);
        assign w_idx_inc   = r_idx + IW'(1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= S_INIT;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_n     <= '0;
                r_lfsr  <= SEED;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_idx   <= w_idx_nxt;
                r_n     <= w_n_nxt;
                r_lfsr  <= w_lfsr_nxt;
            end
        end

        // The LFSR only moves on a draw, so a channel's delay sequence is
        // independent of handshake timing on any channel.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_idx_nxt   = r_idx;
            w_n_nxt     = r_n;
            w_lfsr_nxt  = r_lfsr;
            w_val       = 1'b0;
            w_chan_done = 1'b0;
            case (r_state)
                S_INIT: begin
                    w_n_nxt = w_n_clamp;
                    if (w_n_clamp == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_lfsr_nxt = w_lfsr_step;
                        if (w_d == 32'd0) begin
                            w_state_nxt = S_VALID;
                        end else begin
                            w_state_nxt = S_DELAY;
                            w_cnt_nxt   = w_d - 32'd1;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_cnt == 32'd0) begin
                        w_state_nxt = S_VALID;
                    end else begin
                        w_cnt_nxt = r_cnt - 32'd1;
                    end
                end
                S_VALID: begin
                    w_val = 1'b1;
                    if (rdy[c]) begin
                        w_idx_nxt = w_idx_inc;
                        if (w_idx_inc == r_n) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_lfsr_nxt = w_lfsr_step;
                            if (w_d == 32'd0) begin
                                w_state_nxt = S_VALID;
                            end else begin
                                w_state_nxt = S_DELAY;
                                w_cnt_nxt   = w_d - 32'd1;
                            end
                        end
                    end
                end
                default: begin
                    w_chan_done = 1'b1;
                end
            endcase
        end

        // Outside VALID the payload shows the last issued entry (entry 0 before any fire).
        assign w_rd_idx = ((r_state == S_VALID) || (r_idx == '0)) ? r_idx : (r_idx - IW'(1));
        assign w_addr   = BASE + AW'(w_rd_idx);

        assign val[c]                               = w_val;
        assign chan_done[c]                         = w_chan_done;
        assign msg[c*p_msg_nbits +: p_msg_nbits]    = m[w_addr];
    end

    assign done = &chan_done;

endmodule
